// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package seq_multiplier_pkg;

   localparam int DEF_WIDTH = 32;

   // 2'b11 is unused; the FSM treats it as IDLE.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake plus operands and product between issue logic and multiplier.
interface seq_multiplier_if
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product_hi;
   logic [WIDTH-1:0] product_lo;

   // Issuing control logic side.
   modport master (
      output start, a, b,
      input  busy, done, product_hi, product_lo
   );

   // Multiplier side.
   modport slave (
      input  start, a, b,
      output busy, done, product_hi, product_lo
   );

endinterface

// File: rtl/seq_multiplier_mul_step.sv
// One shift-and-add iteration built around a single WIDTH-bit adder with carry-out.
module mul_adder
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   // Carry-in is tied to 0; the carry-out belongs to the product.
   assign {carry, sum} = {1'b0, x} + {1'b0, y};

endmodule

module mul_step
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] p_hi,
   input  logic [WIDTH-1:0] p_lo,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] next_hi,
   output logic [WIDTH-1:0] next_lo
);

   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] sum;
   logic             carry;

   // Adding zero when the multiplier bit is clear keeps one adder in the path.
   assign addend = p_lo[0] ? m : '0;

   mul_adder #(.WIDTH(WIDTH)) u_adder (
      .x     (p_hi),
      .y     (addend),
      .sum   (sum),
      .carry (carry)
   );

   // Shift {carry, sum, p_lo} right by one: carry enters the MSB, sum[0] moves into p_lo.
   assign next_hi = {carry, sum[WIDTH-1:1]};
   assign next_lo = {sum[0], p_lo[WIDTH-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned multiplier: FSM, iteration counter and product registers.
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   seq_multiplier_if.slave   bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] p_hi;
   logic [WIDTH-1:0] p_lo;
   logic [WIDTH-1:0] next_hi;
   logic [WIDTH-1:0] next_lo;
   logic             busy_r;
   logic             done_r;

   mul_step #(.WIDTH(WIDTH)) u_step (
      .p_hi    (p_hi),
      .p_lo    (p_lo),
      .m       (m),
      .next_hi (next_hi),
      .next_lo (next_lo)
   );

   // FSM with registered busy/done; one partial product retired per RUN cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         m      <= '0;
         p_hi   <= '0;
         p_lo   <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  m      <= bus.a;
                  p_hi   <= '0;
                  p_lo   <= bus.b;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               p_hi <= next_hi;
               p_lo <= next_lo;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  done_r <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.product_hi = p_hi;
   assign bus.product_lo = p_lo;

endmodule
